// File: rtl/sample_frame_reader.sv
// sample_frame_reader: N-entry sample ring buffer that streams the N most
// recent samples, oldest first, over a valid/ready handshake.
// Optional feature: define OVERRUN_DETECT_EN to enable the sticky overrun flag;
// without it overrun is tied low and overwritten entries stream as newer data.
module sample_frame_reader #(
  parameter int N = 256
) (
  input  logic        clk_10MHz,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_strobe,
  input  logic        frame_req,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        filled,
  output logic        busy,
  output logic        overrun
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FILL, READY, READ} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [11:0] r_mem [N];
  logic [11:0] r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_rd_cnt;
  logic [CW-1:0] r_fill_cnt;
  logic          r_filled;
  logic          w_accept;
  logic          w_xfer;
  logic          w_last_xfer;
  logic          w_fill_done;
  logic          w_rd_en;
  logic [AW-1:0] w_start;
  logic [AW-1:0] w_rd_addr;

  // A strobe coincident with acceptance is written at wr_ptr and becomes the
  // newest sample, so the oldest sample sits one slot past it.
  assign w_start   = r_wr_ptr + AW'(sample_strobe);
  assign w_rd_addr = w_accept ? w_start : r_rd_addr + AW'(1);
  assign w_rd_en   = w_accept | (w_xfer & ~w_last_xfer);

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_xfer       = 1'b0;
    w_last_xfer  = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      FILL: begin
        if (sample_strobe && r_fill_cnt == CW'(N - 1)) begin
          w_fill_done  = 1'b1;
          w_state_next = READY;
        end
      end
      READY: begin
        if (frame_req) begin
          w_accept     = 1'b1;
          w_state_next = READ;
        end
      end
      READ: begin
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_rd_cnt == AW'(N - 1)) begin
            w_last_xfer  = 1'b1;
            w_state_next = READY;
          end
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // Sample storage with registered read; a same-address write returns the old value.
  always_ff @(posedge clk_10MHz) begin
    if (sample_strobe) r_mem[r_wr_ptr] <= sample_in;
    if (w_rd_en)       r_rd_data <= r_mem[w_rd_addr];
  end

  // Write pointer, saturating fill counter and read address/count tracking.
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_filled   <= 1'b0;
    end else begin
      if (sample_strobe) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (sample_strobe && r_fill_cnt != CW'(N)) r_fill_cnt <= r_fill_cnt + CW'(1);
      if (w_fill_done) r_filled <= 1'b1;
      if (w_accept) begin
        r_rd_addr <= w_start;
        r_rd_cnt  <= '0;
      end else if (w_xfer && !w_last_xfer) begin
        r_rd_addr <= r_rd_addr + AW'(1);
        r_rd_cnt  <= r_rd_cnt + AW'(1);
      end
    end
  end

`ifdef OVERRUN_DETECT_EN
  logic [AW-1:0] r_start;
  logic [AW-1:0] w_frame_idx;
  logic          r_overrun;

  // Position within the current frame of the slot being written.
  assign w_frame_idx = r_wr_ptr - r_start;

  // Sticky flag: a strobe in READ hit a slot not yet handed downstream
  // (the slot transferring this cycle is already latched, so it is safe).
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      r_start   <= '0;
      r_overrun <= 1'b0;
    end else if (w_accept) begin
      r_start   <= w_start;
      r_overrun <= 1'b0;
    end else if (r_state == READ && sample_strobe &&
                 (w_frame_idx > r_rd_cnt || (w_frame_idx == r_rd_cnt && !w_xfer))) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign busy      = (r_state == READ);
  assign out_valid = busy;
  assign out_last  = busy && (r_rd_cnt == AW'(N - 1));
  assign out_data  = busy ? r_rd_data : 12'd0;
  assign filled    = r_filled;

endmodule

// File: tb/tb_sample_frame_reader.sv
// Directed bench for sample_frame_reader with N=8: vector table for the
// basic, wrap-around and coincident-strobe frames, then hand-written
// sequences for stalls, overrun and reset during readout.
module tb_sample_frame_reader;

  localparam int N = 8;
`ifdef OVERRUN_DETECT_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_strobe = 1'b0;
  logic        frame_req = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic        out_valid, out_last, filled, busy, overrun;

  int total = 0;
  int bad   = 0;

  // Bench-side model of the ring buffer contents and write pointer.
  logic [11:0] mdl [N];
  int          mwp = 0;

  typedef struct {
    bit s; int v; bit q; bit r;
    bit ev; int ed; bit el; bit eb; bit ef;
  } vec_t;
  vec_t vq[$];

  sample_frame_reader #(.N(N)) dut (
    .clk_10MHz(clk), .rst(rst), .sample_in(sample_in),
    .sample_strobe(sample_strobe), .frame_req(frame_req), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .filled(filled), .busy(busy), .overrun(overrun)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int v, input bit q, input bit r);
    sample_strobe = s;
    sample_in     = 12'(v);
    frame_req     = q;
    out_ready     = r;
    if (s) begin
      mdl[mwp] = 12'(v);
      mwp      = (mwp + 1) % N;
    end
  endtask

  function automatic void addv(bit s, int v, bit q, bit r, bit ev, int ed, bit el, bit eb, bit ef);
    vec_t t;
    t = '{s: s, v: v, q: q, r: r, ev: ev, ed: ed, el: el, eb: eb, ef: ef};
    vq.push_back(t);
  endfunction

  initial begin
    int idx;
    int st;
    logic [11:0] first;
    int pat [4] = '{1, 0, 0, 1};

    // Frame 1: fill with 1..8, then read 1..8.
    for (int k = 1; k <= 8; k++) addv(1, k, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) addv(0, 0, 0, 1, 1, k, (k == 8), 1, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 0, 1);
    // Frame 2: 9..11 written, read wraps to 4..11.
    for (int k = 9; k <= 11; k++) addv(1, k, 0, 1, 0, 0, 0, 0, 1);
    addv(0, 0, 1, 1, 0, 0, 0, 0, 1);
    for (int k = 4; k <= 11; k++) addv(0, 0, 0, 1, 1, k, (k == 11), 1, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 0, 1);
    // Frame 3: strobe of 12 coincident with request -> 5..12.
    addv(1, 12, 1, 1, 0, 0, 0, 0, 1);
    for (int k = 5; k <= 12; k++) addv(0, 0, 0, 1, 1, k, (k == 12), 1, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Reset state.
    step();
    step();
    chk("rst.valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.filled", filled, 0);
    chk("rst.data", out_data, 0);
    chk("rst.last", out_last, 0);
    chk("rst.overrun", overrun, 0);
    rst = 1'b0;
    mwp = 0;

    foreach (vq[i]) begin
      drive(vq[i].s, vq[i].v, vq[i].q, vq[i].r);
      chk($sformatf("v%0d.valid", i), out_valid, vq[i].ev);
      chk($sformatf("v%0d.busy", i), busy, vq[i].eb);
      chk($sformatf("v%0d.filled", i), filled, vq[i].ef);
      chk($sformatf("v%0d.last", i), out_last, vq[i].el);
      chk($sformatf("v%0d.overrun", i), overrun, 0);
      if (vq[i].ev) chk($sformatf("v%0d.data", i), out_data, vq[i].ed);
      $display("vec %0d: valid=%0d data=%0d last=%0d busy=%0d filled=%0d",
               i, out_valid, out_data, out_last, busy, filled);
      step();
    end

    // Stall pattern 1,0,0,1 with frame_req held high during READ.
    drive(0, 0, 1, 0);
    st = mwp;
    step();
    idx = 0;
    for (int c = 0; c < 40 && idx < N; c++) begin
      drive(0, 0, 1, pat[c % 4][0]);
      chk($sformatf("stall%0d.valid", c), out_valid, 1);
      chk($sformatf("stall%0d.data", c), out_data, mdl[(st + idx) % N]);
      chk($sformatf("stall%0d.last", c), out_last, (idx == N - 1));
      $display("stall cyc %0d: ready=%0d data=%0d last=%0d", c, out_ready, out_data, out_last);
      if (pat[c % 4] != 0) idx++;
      step();
    end
    chk("stall.count", idx, N);
    drive(0, 0, 0, 1);
    chk("stall.end_valid", out_valid, 0);
    chk("stall.end_busy", busy, 0);
    step();

    // Long stall with strobes every other cycle overwrites unread entries.
    drive(0, 0, 1, 0);
    st = mwp;
    first = mdl[st];
    step();
    for (int c = 0; c < 20; c++) begin
      drive((c % 2) == 0, 100 + c, 0, 0);
      chk($sformatf("ovr%0d.data", c), out_data, first);
      step();
    end
    drive(0, 0, 0, 0);
    chk("ovr.flag", overrun, OVR_EN);
    $display("overrun after stall: %0d", overrun);
    idx = 0;
    for (int c = 0; c < 40 && idx < N; c++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("drain%0d.data", c), out_data, (idx == 0) ? first : mdl[(st + idx) % N]);
      idx++;
      step();
    end
    chk("drain.count", idx, N);
    drive(0, 0, 1, 1);
    step();
    drive(0, 0, 0, 1);
    chk("ovr.clear", overrun, 0);
    chk("ovr.next_valid", out_valid, 1);
    step();

    // Reset while presenting the third sample.
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    chk("pre_rst.busy", busy, 1);
    #10 rst = 1'b1;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.busy", busy, 0);
    chk("arst.filled", filled, 0);
    chk("arst.data", out_data, 0);
    chk("arst.overrun", overrun, 0);
    step();
    rst = 1'b0;
    mwp = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 200 + k, 1, 1);
      chk($sformatf("refill%0d.valid", k), out_valid, 0);
      chk($sformatf("refill%0d.filled", k), filled, 0);
      step();
    end
    drive(0, 0, 1, 1);
    chk("refill.filled", filled, 1);
    chk("refill.accept_valid", out_valid, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("refill.data%0d", k), out_data, 200 + k);
      chk($sformatf("refill.last%0d", k), out_last, (k == 7));
      step();
    end
    drive(0, 0, 0, 1);
    chk("refill.done", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
